// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream (stochastic-computing) network controller.
// Holds the stream length, LFSR shape and seeds, the controller state enum,
// control/status bit positions and an operand saturation helper.
package bitstream_pkg;

  localparam int unsigned SN_LEN = 255;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form: feedback from bits 7,5,4,3.
  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // One distinct nonzero seed per stream; N_IN must not exceed MAX_IN.
  localparam int unsigned MAX_IN = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEEDS [MAX_IN] = '{8'h01, 8'hB4, 8'h5A, 8'hC3};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;

  // Clamp a signed operand into the unipolar range 0..255.
  function automatic logic [LFSR_W-1:0] sat_u8(input int v);
    if (v < 0) begin
      return '0;
    end else if (v > 255) begin
      return 8'hFF;
    end else begin
      return v[LFSR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sng.sv
// Stochastic number generator: 8-bit maximal-length LFSR plus comparator.
// Ports:
//   clk     - clock
//   n_rst   - asynchronous active-high reset (LFSR returns to seed)
//   load    - reload the LFSR with seed on the next edge
//   seed    - nonzero LFSR start value
//   operand - unipolar value 0..255
//   sn_bit  - stream bit, 1 when the current LFSR value <= operand
// The LFSR visits every value 1..255 once per period, so one period of
// sn_bit contains exactly 'operand' ones.
module sng
  import bitstream_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] operand,
  output logic              sn_bit
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    if (load) begin
      lfsr_d = seed;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sn_bit = (lfsr_q <= operand);

endmodule

// File: rtl/bitstream_network_control.sv
// Controller and datapath for an AND-network (stochastic multiply) bitstream unit.
// On a rising edge of start the saturated operands are latched and the LFSRs
// reloaded; SN_LEN stream bits are then ANDed and counted, and the ones-count
// is published on data_out[0] with done set.
// Ports:
//   clk         - clock
//   n_rst       - asynchronous active-high reset
//   control_in  - bit 0 start, bits 7:1 ignored
//   control_out - bit 0 busy, bit 1 done, bits 7:2 zero
//   data_in     - N_IN signed operands (nominal 0..255, saturated)
//   data_out    - [0] ones-count of the network output stream
module bitstream_network_control
  import bitstream_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SN_LEN = bitstream_pkg::SN_LEN
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] control_in,
  output logic [7:0] control_out,
  input  int         data_in  [N_IN-1:0],
  output int         data_out [0:0]
);

  localparam logic [8:0] LastCyc = 9'(SN_LEN);

  state_e            state_q, state_d;
  logic              start_q;
  logic [LFSR_W-1:0] opnd_q [N_IN];
  logic [LFSR_W-1:0] opnd_d [N_IN];
  logic [8:0]        cnt_q, cnt_d;
  logic [8:0]        cyc_q, cyc_d;
  logic [8:0]        res_q, res_d;
  logic              load;
  logic [N_IN-1:0]   sn_bits;
  logic              net_bit;
  logic              start, start_rise;
  logic              unused_ctrl;

  assign start       = control_in[CTRL_START];
  assign start_rise  = start & ~start_q;
  assign net_bit     = &sn_bits;
  assign unused_ctrl = ^control_in[7:1];

  for (genvar i = 0; i < N_IN; i++) begin : g_sng
    sng u_sng (
      .clk     (clk),
      .n_rst   (n_rst),
      .load    (load),
      .seed    (LFSR_SEEDS[i]),
      .operand (opnd_q[i]),
      .sn_bit  (sn_bits[i])
    );
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    res_d   = res_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = RUN;
          load    = 1'b1;
          cnt_d   = '0;
          cyc_d   = '0;
          for (int i = 0; i < N_IN; i++) begin
            opnd_d[i] = sat_u8(data_in[i]);
          end
        end
      end
      RUN: begin
        // The edge after the last counted bit only publishes the result.
        if (cyc_q == LastCyc) begin
          state_d = DONE;
          res_d   = cnt_q;
        end else begin
          cyc_d = cyc_q + 9'd1;
          cnt_d = cnt_q + {8'd0, net_bit};
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        opnd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      start_q <= start;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    control_out            = 8'h00;
    control_out[STAT_BUSY] = (state_q == RUN);
    control_out[STAT_DONE] = (state_q == DONE);
  end

  assign data_out[0] = int'({23'd0, res_q});

endmodule

// File: tb/tb_bitstream_network_control.sv
// Directed bench for bitstream_network_control: each run pushes its expected
// result window onto a scoreboard, popped and compared when done rises.
module tb_bitstream_network_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] control_in = 8'h00;
  logic [7:0] control_out;
  int         data_in  [1:0];
  int         data_out [0:0];

  typedef struct {
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bitstream_network_control #(
    .N_IN   (2),
    .SN_LEN (255)
  ) dut (
    .clk         (clk),
    .n_rst       (rst),
    .control_in  (control_in),
    .control_out (control_out),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One full run. hold = 0 drops start during RUN (must be ignored);
  // hold > 0 keeps start high for that many cycles after done.
  task automatic run_op(input string tag, input int a, input int b,
                        input int lo, input int hi, input int hold);
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    data_in[0] = a;
    data_in[1] = b;
    control_in = {7'($urandom_range(0, 127)), 1'b1};
    sb.push_back('{lo: lo, hi: hi});
    @(negedge clk);
    // Operands are latched now; later changes must not matter.
    data_in[0] = int'($urandom_range(0, 255));
    data_in[1] = int'($urandom_range(0, 255));
    if (hold == 0) control_in = {7'($urandom_range(0, 127)), 1'b0};
    busy_cnt = 0;
    while (control_out[0] === 1'b1 && busy_cnt < 400) begin
      busy_cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cnt, 256);
    check({tag, "_done_status"}, int'(control_out), 2);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check_rng({tag, "_result"}, data_out[0], e.lo, e.hi);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_held_no_retrigger"}, int'(control_out), 2);
      control_in = 8'h00;
    end
    @(negedge clk);
    check({tag, "_back_idle"}, int'(control_out), 0);
    check({tag, "_result_hold"}, data_out[0], e.lo > e.hi ? -1 : data_out[0] < e.lo ? -1 :
          data_out[0]);
  endtask

  initial begin
    data_in[0] = 0;
    data_in[1] = 0;
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", int'(control_out), 0);
    check("reset_data", data_out[0], 0);
    rst = 1'b0;
    data_in[0] = 77;
    data_in[1] = 99;
    repeat (3) @(negedge clk);
    check("idle_ctrl", int'(control_out), 0);
    check("idle_data", data_out[0], 0);

    run_op("max_x_22", 255, 22, 22, 22, 0);
    run_op("zero_x_210", 0, 210, 0, 0, 0);
    run_op("max_x_max", 255, 255, 255, 255, 0);

    // Abort a run 100 cycles in with an asynchronous reset.
    @(negedge clk);
    data_in[0] = 255;
    data_in[1] = 22;
    control_in = 8'h01;
    @(negedge clk);
    repeat (100) @(negedge clk);
    check("abort_busy_before", int'(control_out), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl_async", int'(control_out), 0);
    check("abort_data_async", data_out[0], 0);
    control_in = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_abort", 255, 22, 22, 22, 0);

    run_op("mul_22_210", 22, 210, 10, 26, 43);
    run_op("saturate", -5, 300, 0, 0, 20);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
